// File: rtl/nios2test_nios2_gen2_0_cpu_div_cell.sv
// Multi-cycle restoring radix-2 divider for div/divu: fixed 33-cycle latency from the
// start-sampling edge to done, with sign correction and abort support.
module nios2test_nios2_gen2_0_cpu_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic              E_div_start,
    input  logic              E_div_signed,
    input  logic              M_div_abort,
    output logic [DATA_W-1:0] M_div_quot,
    output logic [DATA_W-1:0] M_div_rem,
    output logic              M_div_busy,
    output logic              M_div_done
);

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  dvd_p0;
    logic [DATA_W-1:0]  dvs_p0;
    logic [DATA_W:0]    prem_p0;
    logic               neg_quot_p0;
    logic               neg_rem_p0;
    logic               div_zero_p0;

    logic [DATA_W:0]    shift_p0;
    logic [DATA_W:0]    diff_p0;
    logic               last_iter;

    // Magnitude of a possibly-negative operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic              neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // The dividend register doubles as the quotient: its MSB feeds the partial
    // remainder and the new quotient bit enters at the LSB.
    assign shift_p0  = {prem_p0[DATA_W-1:0], dvd_p0[DATA_W-1]};
    assign diff_p0   = shift_p0 - {1'b0, dvs_p0};
    assign last_iter = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_p0      <= '0;
            dvs_p0      <= '0;
            prem_p0     <= '0;
            neg_quot_p0 <= 1'b0;
            neg_rem_p0  <= 1'b0;
            div_zero_p0 <= 1'b0;
            M_div_quot  <= '0;
            M_div_rem   <= '0;
            M_div_busy  <= 1'b0;
            M_div_done  <= 1'b0;
        end else begin
            M_div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (E_div_start) begin
                        dvd_p0      <= abs_val(E_src1, E_div_signed);
                        dvs_p0      <= abs_val(E_src2, E_div_signed);
                        prem_p0     <= '0;
                        neg_quot_p0 <= E_div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
                        neg_rem_p0  <= E_div_signed & E_src1[DATA_W-1];
                        div_zero_p0 <= (E_src2 == '0);
                        cnt         <= '0;
                        M_div_busy  <= 1'b1;
                        state       <= ITER;
                    end
                end
                ITER: begin
                    if (M_div_abort) begin
                        M_div_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        if (!diff_p0[DATA_W]) begin
                            prem_p0 <= diff_p0;
                            dvd_p0  <= {dvd_p0[DATA_W-2:0], 1'b1};
                        end else begin
                            prem_p0 <= shift_p0;
                            dvd_p0  <= {dvd_p0[DATA_W-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (last_iter) state <= FIX;
                    end
                end
                FIX: begin
                    // ---- stage boundary: sign-corrected result to the output registers ----
                    if (!M_div_abort) begin
                        // Divide-by-zero bypasses quotient negation; the remainder
                        // naturally reconstructs the original dividend.
                        M_div_quot <= div_zero_p0 ? '1 : cond_neg(dvd_p0, neg_quot_p0);
                        M_div_rem  <= cond_neg(prem_p0[DATA_W-1:0], neg_rem_p0);
                        M_div_done <= 1'b1;
                    end
                    M_div_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    M_div_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nios2test_nios2_gen2_0_cpu_div_cell.md
NIOS2TEST_NIOS2_GEN2_0_CPU_DIV_CELL -- requirements
Module: nios2test_nios2_gen2_0_cpu_div_cell

Interface
REQ-001 SHALL use one clock and an asynchronous active-low reset: clk (rising edge) and reset_n.
REQ-002 SHALL have ports: clk  in  1  clock.
REQ-003 reset_n  in  1  async active-low reset.
REQ-004 E_src1  in  32  dividend.
REQ-005 E_src2  in  32  divisor.
REQ-006 E_div_start  in  1  start request, sampled only in IDLE.
REQ-007 E_div_signed  in  1  1 = div (two's complement), 0 = divu; sampled with start.
REQ-008 M_div_abort  in  1  pipeline flush; cancels an operation in progress.
REQ-009 M_div_quot  out  32  quotient.
REQ-010 M_div_rem  out  32  remainder, with the same sign as the dividend.
REQ-011 M_div_busy  out  1  high while an operation is in progress.
REQ-012 M_div_done  out  1  one-cycle pulse; results are valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, ITER and FIX; the state register SHALL be binary-encoded.
REQ-014 IDLE with E_div_start=1 at edge k: SHALL capture |src1|, |src2|, and the sign flags (signed mode only), clear the 6-bit counter, and move to ITER.
REQ-015 ITER: SHALL perform one restoring radix-2 step per edge, using a 33-bit partial remainder: shift in the next dividend MSB, subtract the divisor, set the quotient bit if the result is non-negative, and restore otherwise.
REQ-016 After 32 ITER edges (edges k+1..k+32), SHALL move to FIX.
REQ-017 FIX at edge k+33: SHALL register sign-corrected quot/rem, pulse M_div_done for the following cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed: done is high exactly 33 cycles after the start-sampling edge, independent of the operand values.
REQ-019 M_div_busy SHALL be 1 in ITER and FIX, and 0 in IDLE, including the done cycle.
REQ-020 E_div_start SHALL be ignored while busy; no queuing.
REQ-021 Signed correction: quot SHALL be negated when the operand signs differ; rem SHALL be negated when the dividend is negative.
REQ-022 Divisor zero: SHALL still take the full latency and return quot=0xFFFFFFFF and rem=dividend (unmodified, either mode).
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF: SHALL return quot=0x80000000 and rem=0, with no trap.
REQ-024 Abs of 0x80000000 SHALL be taken as unsigned 0x80000000; 33-bit internal width guarantees no overflow.
REQ-025 M_div_abort=1 while busy: SHALL return to IDLE at the next edge with no done pulse; quot/rem SHALL keep their previous values.
REQ-026 M_div_abort in IDLE SHALL have no effect; start and abort in the same IDLE cycle SHALL start the operation.
REQ-027 M_div_quot/M_div_rem SHALL hold their values from done until the next done.
REQ-028 Operand inputs SHALL NOT need to remain stable after the start edge.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: state=IDLE, counter=0, M_div_quot=0, M_div_rem=0, M_div_busy=0, M_div_done=0, and clear all internal registers.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no done pulse SHALL follow deassertion.
REQ-031 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-032 divu 100/7: start at edge k -> done at cycle k+33 with quot=14, rem=2; busy high for cycles k+1..k+33 exclusive of done.
REQ-033 div -7/2 (0xFFFFFFF9, 2) -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1); div 7/-2 -> quot=-3, rem=1.
REQ-034 div 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; divu 5/0 -> quot=0xFFFFFFFF, rem=5.
REQ-035 Abort at ITER cycle 10 -> no done, busy=0 next cycle, outputs keep previous values; a new start the following cycle completes normally.
REQ-036 Start held high continuously with changing operands -> only the operands from the first sampled start are used; the next operation starts in the cycle after done (back-to-back spacing 34 cycles).
REQ-037 reset_n pulsed low at ITER cycle 20 -> all outputs 0 immediately; no done; random 10k-operand compare against a reference model in both modes.
